// File: rtl/pipelined_lookahead_borrow_subtractor.sv
// rtl/pipelined_lookahead_borrow_subtractor.sv - pipelined WIDTH-bit subtractor, one lookahead nibble per stage
// Elastic valid/ready pipeline computing a - b - borrow_in with registered inter-nibble borrows.

module borrow_lookahead_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_bin,
    output logic [3:0] o_d,
    output logic       o_bout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_bor;
    logic       w_grp_g;
    logic       w_grp_p;

    // A borrow is generated where a=0,b=1 and passes through where the bits are equal.
    assign w_g = ~i_a & i_b;
    assign w_p = ~(i_a ^ i_b);

    assign w_bor[0] = i_bin;
    assign w_bor[1] = w_g[0] | (w_p[0] & i_bin);
    assign w_bor[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_bin);
    assign w_bor[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                    | (w_p[2] & w_p[1] & w_p[0] & i_bin);

    assign w_grp_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign w_grp_p = &w_p;

    assign o_bout = w_grp_g | (w_grp_p & i_bin);
    assign o_d    = i_a ^ i_b ^ w_bor;

endmodule

module pipelined_lookahead_borrow_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int NSTAGE = WIDTH / 4;

    logic                  w_advance;
    logic [NSTAGE:0]       r_vld;
    logic [NSTAGE:0]       r_bor;
    logic [NSTAGE:0]       r_sa;
    logic [NSTAGE:0]       r_sb;
    logic [WIDTH-1:0]      r_a [NSTAGE];
    logic [WIDTH-1:0]      r_b [NSTAGE];
    logic [WIDTH-1:0]      r_d [1:NSTAGE];
    logic [WIDTH-1:0]      w_dnext [NSTAGE];
    logic [NSTAGE-1:0]     w_bo;

    // Level 0 holds the captured operands; level k+1 holds the result of nibble k.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [3:0] w_nib;

        borrow_lookahead_4 u_bla (
            .i_a    (r_a[k][4*k +: 4]),
            .i_b    (r_b[k][4*k +: 4]),
            .i_bin  (r_bor[k]),
            .o_d    (w_nib),
            .o_bout (w_bo[k])
        );

        if (k == 0) begin : g_first
            assign w_dnext[k] = WIDTH'(w_nib);
        end else begin : g_rest
            assign w_dnext[k] = r_d[k] | (WIDTH'(w_nib) << (4 * k));
        end
    end

    assign w_advance = ~r_vld[NSTAGE] | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_bor <= '0;
            r_sa  <= '0;
            r_sb  <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            for (int k = 1; k <= NSTAGE; k++) begin
                r_d[k] <= '0;
            end
        end else if (w_advance) begin
            r_vld[0] <= in_valid;
            r_a[0]   <= a;
            r_b[0]   <= b;
            r_bor[0] <= borrow_in;
            r_sa[0]  <= a[WIDTH-1];
            r_sb[0]  <= b[WIDTH-1];
            for (int k = 1; k < NSTAGE; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
            end
            for (int k = 0; k < NSTAGE; k++) begin
                r_vld[k+1] <= r_vld[k];
                r_bor[k+1] <= w_bo[k];
                r_sa[k+1]  <= r_sa[k];
                r_sb[k+1]  <= r_sb[k];
                r_d[k+1]   <= w_dnext[k];
            end
        end
    end

    assign in_ready   = w_advance;
    assign out_valid  = r_vld[NSTAGE];
    assign diff       = r_d[NSTAGE];
    assign borrow_out = r_bor[NSTAGE];
    assign overflow   = (r_sa[NSTAGE] ^ r_sb[NSTAGE]) & (r_d[NSTAGE][WIDTH-1] ^ r_sa[NSTAGE]);

endmodule

// File: tb/tb_pipelined_lookahead_borrow_subtractor.sv
// tb/tb_pipelined_lookahead_borrow_subtractor.sv - directed and randomised checks of the pipelined subtractor
module tb_pipelined_lookahead_borrow_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow_out;
    logic        overflow;

    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    logic [17:0] q[$];
    logic        stalled_prev = 1'b0;
    logic [15:0] hold_d;
    logic        hold_bo;
    logic        hold_ov;
    logic [15:0] tb_a;
    logic [15:0] tb_b;
    logic        tb_bin;
    logic        acc;
    logic        pend;
    int          n;
    int          pops0;

    pipelined_lookahead_borrow_subtractor #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result {overflow, borrow, diff} from integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        int ud;
        int sd;
        logic [17:0] r;
        ud = int'(x) - int'(y) - int'(c);
        sd = int'($signed(x)) - int'($signed(y)) - int'(c);
        r[15:0] = ud[15:0];
        r[16]   = (ud < 0);
        r[17]   = (sd < -32768) || (sd > 32767);
        return r;
    endfunction

    // One clock cycle: drive, score the output beat, record any accepted input beat.
    task automatic step(input logic v, input logic ordy);
        logic [17:0] e;
        in_valid  = v;
        out_ready = ordy;
        a         = tb_a;
        b         = tb_b;
        borrow_in = tb_bin;
        #1;
        if (stalled_prev) begin
            chk("frozen_valid", out_valid, 1);
            chk("frozen_diff", diff, hold_d);
            chk("frozen_borrow", borrow_out, hold_bo);
            chk("frozen_ovf", overflow, hold_ov);
        end
        if (out_valid && out_ready) begin
            chk("sb_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                pops++;
                chk("sb_diff", diff, e[15:0]);
                chk("sb_borrow", borrow_out, e[16]);
                chk("sb_ovf", overflow, e[17]);
            end
        end
        stalled_prev = out_valid && !out_ready;
        hold_d  = diff;
        hold_bo = borrow_out;
        hold_ov = overflow;
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(tb_a, tb_b, tb_bin));
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipe; result must appear exactly four edges after acceptance.
    task automatic one_beat(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic c, input logic [15:0] ed, input logic eb, input logic eo);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = x;
        b         = y;
        borrow_in = c;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_lat0"}, out_valid, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk({tag, "_early"}, out_valid, 0);
        end
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow_out, eb);
        chk({tag, "_ovf"}, overflow, eo);
        @(posedge clk);
        #1;
        chk({tag, "_drained"}, out_valid, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        out_ready = 1'b1;
        tb_a      = '0;
        tb_b      = '0;
        tb_bin    = 1'b0;
        acc       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        one_beat("basic",     16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        one_beat("wrap",      16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        one_beat("neg_ovf",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        one_beat("eq_bin",    16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        one_beat("pos_ovf",   16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        one_beat("full_bout", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Eight back-to-back beats: outputs valid on eight consecutive cycles.
        tb_b   = 16'h0101;
        tb_bin = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tb_a = (j < 8) ? 16'(j * 16'h1111) : 16'h0;
            step(j < 8, 1'b1);
            chk("stream_valid", out_valid, (j >= 4 && j <= 11));
        end
        chk("stream_pops", pops, 8);
        chk("stream_empty", q.size(), 0);

        // Stall the output for five cycles while upstream keeps offering beats.
        n = 0;
        pops0 = pops;
        for (int j = 0; j < 30; j++) begin
            tb_a   = 16'(16'h1000 + n * 16'h0123);
            tb_b   = 16'(n * 16'h0321);
            tb_bin = n[0];
            step(n < 12, !(j >= 6 && j < 11));
            if (acc) n++;
            if (j == 9) chk("stall_in_ready", in_ready, 0);
            if (j == 10) chk("stall_no_accept", n, 6);
        end
        chk("stall_accepted", n, 12);
        chk("stall_pops", pops - pops0, 12);
        chk("stall_empty", q.size(), 0);

        // Reset with three beats in flight: none may emerge.
        for (int j = 0; j < 3; j++) begin
            tb_a = 16'(16'hA000 + j);
            tb_b = 16'h0001;
            tb_bin = 1'b0;
            step(1'b1, 1'b1);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        stalled_prev = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_valid", out_valid, 0);
        for (int j = 0; j < 6; j++) begin
            step(1'b0, 1'b1);
            chk("midrst_quiet", out_valid, 0);
        end
        one_beat("post_rst", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);

        // Random traffic with random backpressure against the integer model.
        pend  = 1'b0;
        pops0 = pops;
        n     = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend) begin
                pend   = ($urandom_range(0, 3) != 0);
                tb_a   = 16'($urandom);
                tb_b   = 16'($urandom);
                tb_bin = 1'($urandom_range(0, 1));
            end
            step(pend, $urandom_range(0, 3) != 0);
            if (acc) begin
                pend = 1'b0;
                n++;
            end
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        chk("rand_all_out", pops - pops0, n);
        chk("rand_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
